// File: rtl/l1_arb_pkg.sv
// rtl/l1_arb_pkg.sv - shared types and helpers for the N-port L1 arbiter
package l1_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l1_arb_picker.sv
// rtl/l1_arb_picker.sv - circular first-set search over the request vector from a start index
module l1_arb_picker
  import l1_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IW = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        start,
  output logic [IW-1:0]        winner,
  output logic                 any_req
);

  // Two passes give wrap-around order without a modulo: start..top, then 0..start-1.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!any_req && req[j] && (IW'(j) >= start)) begin
        winner  = IW'(j);
        any_req = 1'b1;
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!any_req && req[j] && (IW'(j) < start)) begin
        winner  = IW'(j);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_arbiter_n.sv
// rtl/l1_arbiter_n.sv - N-port L1 to system-bus arbiter, one transaction in flight; L1_ARB_RR_EN selects round-robin
module l1_arbiter_n
  import l1_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  localparam int BE_W     = DATA_W / 8,
  localparam int IW       = idx_w(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] s_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   s_be,
  input  logic [NUM_PORTS-1:0]        s_we,
  input  logic [NUM_PORTS-1:0]        s_req,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [NUM_PORTS-1:0]        s_ready,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  output logic [BE_W-1:0]             m_be,
  output logic                        m_we,
  output logic                        m_req,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic                        m_ready,
  output logic                        grant_valid,
  output logic [IW-1:0]               grant_idx
);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("l1_arbiter_n: NUM_PORTS out of range");
  end

  arb_state_t    state, state_nxt;
  logic [IW-1:0] grant_nxt;
  logic [IW-1:0] start;
  logic [IW-1:0] winner;
  logic          any_req;

  l1_arb_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req     (s_req),
    .start   (start),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef L1_ARB_RR_EN
  logic [IW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= IW'(NUM_PORTS - 1);
    end else if (state == ARB_IDLE && any_req) begin
      rr_ptr <= winner;
    end
  end

  assign start = (rr_ptr == IW'(NUM_PORTS - 1)) ? '0 : rr_ptr + 1'b1;
`else
  assign start = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
    end
  end

  // Grant is captured only in IDLE; a dropped s_req during BUSY cannot cancel the bus cycle.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_nxt = ARB_BUSY;
          grant_nxt = winner;
        end
      end
      ARB_BUSY: begin
        if (m_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    m_we    = 1'b0;
    s_ready = '0;
    if (state == ARB_BUSY) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_idx == IW'(i)) begin
          m_addr     = s_addr[i*ADDR_W +: ADDR_W];
          m_wdata    = s_wdata[i*DATA_W +: DATA_W];
          m_be       = s_be[i*BE_W +: BE_W];
          m_we       = s_we[i];
          s_ready[i] = m_ready;
        end
      end
    end
  end

  assign m_req       = (state == ARB_BUSY);
  assign grant_valid = (state == ARB_BUSY);
  assign s_rdata     = m_rdata;

endmodule

// File: tb/tb_l1_arbiter_n.sv
// tb/tb_l1_arbiter_n.sv - directed self-checking bench for l1_arbiter_n at NUM_PORTS=4
module tb_l1_arbiter_n;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic             clk;
  logic             rst;
  logic [NP*AW-1:0] s_addr;
  logic [NP*DW-1:0] s_wdata;
  logic [NP*BW-1:0] s_be;
  logic [NP-1:0]    s_we;
  logic [NP-1:0]    s_req;
  logic [DW-1:0]    s_rdata;
  logic [NP-1:0]    s_ready;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [BW-1:0]    m_be;
  logic             m_we;
  logic             m_req;
  logic [DW-1:0]    m_rdata;
  logic             m_ready;
  logic             grant_valid;
  logic [1:0]       grant_idx;

  int checks = 0;
  int errors = 0;

  l1_arbiter_n #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_be        (s_be),
    .s_we        (s_we),
    .s_req       (s_req),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_be        (m_be),
    .m_we        (m_we),
    .m_req       (m_req),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be, input logic we);
    s_addr[p*AW +: AW]  = a;
    s_wdata[p*DW +: DW] = d;
    s_be[p*BW +: BW]    = be;
    s_we[p]             = we;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req got %b exp 0", m_req); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid got %b exp 0", grant_valid); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant_idx got %0d exp 0", grant_idx); end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_s_ready got %b exp 0000", s_ready); end
    checks++; if (m_addr !== 32'h0 || m_we !== 1'b0 || m_be !== 4'h0 || m_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_m_fields got addr %h we %b be %h wdata %h exp all 0", m_addr, m_we, m_be, m_wdata);
    end
  endtask

  task automatic test_spurious_ready;
    s_req   = '0;
    m_ready = 1'b1;
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL spurious_s_ready got %b exp 0000", s_ready); end
    tick();
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL spurious_s_ready_after got %b exp 0000", s_ready); end
    checks++; if (grant_valid !== 1'b0 || m_req !== 1'b0) begin
      errors++; $display("FAIL spurious_idle got grant_valid %b m_req %b exp 0 0", grant_valid, m_req);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_single_port;
    int pulses;
    pulses = 0;
    set_port(1, 32'h0000_1000, 32'h0, 4'hF, 1'b0);
    s_req = 4'b0010;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL single_m_req_cycle0 got %b exp 0", m_req); end
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL single_m_req_cycle1 got %b exp 1", m_req); end
    checks++; if (m_addr !== 32'h0000_1000) begin errors++; $display("FAIL single_m_addr got %h exp 00001000", m_addr); end
    checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL single_grant_idx got %0d exp 1", grant_idx); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL single_m_we got %b exp 0", m_we); end
    for (int w = 0; w < 3; w++) begin
      if (s_ready != 4'b0000) pulses++;
      tick();
    end
    m_rdata = 32'hDEAD_BEEF;
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL single_s_ready got %b exp 0010", s_ready); end
    checks++; if (s_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_s_rdata got %h exp deadbeef", s_rdata); end
    if (s_ready != 4'b0000) pulses++;
    tick();
    s_req   = '0;
    m_ready = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_back_idle got %b exp 0", grant_valid); end
    if (s_ready != 4'b0000) pulses++;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulse_count got %0d exp 1", pulses); end
  endtask

  task automatic test_write;
    set_port(0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b0011, 1'b1);
    s_req = 4'b0001;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++; if (m_we !== 1'b1 || m_wdata !== 32'hA5A5_A5A5 || m_be !== 4'b0011 || grant_idx !== 2'd0) begin
        errors++; $display("FAIL write_fields cyc %0d got we %b wdata %h be %b idx %0d exp 1 a5a5a5a5 0011 0",
                           c, m_we, m_wdata, m_be, grant_idx);
      end
      tick();
    end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL write_s_ready got %b exp 0001", s_ready); end
    tick();
    s_req   = '0;
    m_ready = 1'b0;
    s_we    = '0;
  endtask

`ifdef L1_ARB_RR_EN
  task automatic test_round_robin;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    s_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (grant_idx !== 2'(exp_seq[k]) || grant_valid !== 1'b1) begin
        errors++; $display("FAIL rr_grant step %0d got idx %0d valid %b exp %0d 1", k, grant_idx, grant_valid, exp_seq[k]);
      end
      m_ready = 1'b1;
      #1;
      checks++; if (s_ready !== (4'b0001 << exp_seq[k])) begin
        errors++; $display("FAIL rr_s_ready step %0d got %b exp %b", k, s_ready, 4'b0001 << exp_seq[k]);
      end
      tick();
      m_ready = 1'b0;
    end
    s_req = '0;
    tick();
  endtask
`else
  task automatic test_fixed_priority;
    s_req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
        errors++; $display("FAIL prio_grant round %0d got idx %0d valid %b exp 1 1", k, grant_idx, grant_valid);
      end
      m_ready = 1'b1;
      #1;
      checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL prio_s_ready round %0d got %b exp 0010", k, s_ready); end
      tick();
      m_ready = 1'b0;
      #1;
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL prio_idle_gap round %0d got %b exp 0", k, grant_valid); end
    end
    s_req = 4'b1000;
    tick();
    checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL prio_port3 got %0d exp 3", grant_idx); end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b1000) begin errors++; $display("FAIL prio_port3_ready got %b exp 1000", s_ready); end
    tick();
    m_ready = 1'b0;
    s_req   = '0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_busy;
    do_reset();
    s_req = 4'b0100;
    tick();
    checks++; if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL rstbusy_grant got idx %0d valid %b exp 2 1", grant_idx, grant_valid);
    end
    tick();
    s_req = 4'b0101;
    rst   = 1'b1;
    tick();
    checks++; if (m_req !== 1'b0 || grant_valid !== 1'b0) begin
      errors++; $display("FAIL rstbusy_after got m_req %b valid %b exp 0 0", m_req, grant_valid);
    end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rstbusy_s_ready got %b exp 0000", s_ready); end
    rst = 1'b0;
    tick();
    checks++; if (grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL rstbusy_next_grant got idx %0d valid %b exp 0 1", grant_idx, grant_valid);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_req   = '0;
    tick();
  endtask

  initial begin
    rst     = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_be    = '0;
    s_we    = '0;
    s_req   = '0;
    m_rdata = '0;
    m_ready = 1'b0;
    #1;
    test_reset();
    test_spurious_ready();
    test_single_port();
    test_write();
`ifdef L1_ARB_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_arbiter_n.md
# l1_arbiter_n

Parametrised N-port L1 memory arbiter, the successor to the fixed two-port I-cache/D-cache arbiter. It sits in the core tile between any number of L1 requesters (I-cache, D-cache, prefetcher, page-walker) and the single system-bus master port. It serialises one outstanding transaction at a time. Fixed-priority selection is the baseline; round-robin fairness is selectable at compile time.

## Interface
- NUM_PORTS, default 2: requester count, 2..8.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width, multiple of 8. Byte-enable width BE_W = DATA_W/8.
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous and active-high (one clock; polarity and synchronicity fixed).
- s_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
- s_wdata  in  NUM_PORTS*DATA_W  per-port write data.
- s_be  in  NUM_PORTS*BE_W  per-port byte enables.
- s_we  in  NUM_PORTS  per-port write flag.
- s_req  in  NUM_PORTS  per-port request, level, held until that port's s_ready.
- s_rdata  out  DATA_W  read data, broadcast to all ports.
- s_ready  out  NUM_PORTS  one-hot completion strobe.
- m_addr / m_wdata / m_be / m_we / m_req  out  ADDR_W / DATA_W / BE_W / 1 / 1  bus master request.
- m_rdata  in  DATA_W  bus read data.
- m_ready  in  1  bus completion, valid only while m_req=1.
- grant_valid  out  1  transaction in flight.
- grant_idx  out  clog2(NUM_PORTS)  owner of the current transaction.

## Operation
- FSM has two states:
  - IDLE: if any s_req, select a winner, latch it into grant_idx and go to BUSY. Otherwise stay in IDLE.
  - BUSY: m_req=1 and the m_* outputs are muxed from port grant_idx. When m_ready=1, pulse s_ready[grant_idx], then return to IDLE.
- Fixed priority: lowest asserted index wins.
- s_rdata = m_rdata at all times (combinational pass-through). Requesters sample it only on their own s_ready.
- s_ready[i] = m_ready & (state==BUSY) & (grant_idx==i). It is combinational, with zero added latency.
- In IDLE, m_req=0 and m_addr/m_wdata/m_be/m_we are driven 0.
- If a granted requester drops s_req in BUSY, that is a protocol violation. The arbiter must still hold the grant until m_ready, because a bus transaction cannot be cancelled. s_ready still pulses.
- Requests from non-granted ports are ignored and are not latched. They compete again in the next IDLE cycle.
- grant_idx is stable for the entire BUSY interval, and the muxed m_* fields follow it.

## Timing
- Reset values: state IDLE, grant_idx 0, grant_valid 0, m_req 0, all m_* 0, s_ready 0. Round-robin pointer is NUM_PORTS-1, so port 0 is first.
- Request-to-bus latency: s_req rising in cycle 0 gives m_req=1 in cycle 1.
- Completion: m_ready in cycle k gives s_ready in cycle k and IDLE in cycle k+1.
- Minimum one IDLE cycle between transactions, so back-to-back throughput is one transaction per 2 + bus-wait cycles.
- rst asserted mid-BUSY: the next edge returns to the reset state. The in-flight transaction is abandoned, no s_ready is issued, and m_req drops the cycle after the reset edge.
- Simultaneous requests on the same IDLE edge: exactly one port wins. No other port sees s_ready until its own grant.
- m_ready while IDLE: ignored, and no s_ready is produced.

## Configuration
- L1_ARB_RR_EN defined:
  - The round-robin pointer holds the last-granted index and updates on every grant.
  - The search starts at pointer+1, modulo NUM_PORTS, wrapping past NUM_PORTS-1 to 0.
  - A port waits at most NUM_PORTS-1 transactions.
- L1_ARB_RR_EN undefined: fixed priority applies and the pointer register is not built.

## Structure
- Package l1_arb_pkg holds:
  - the FSM state enum (ARB_IDLE, ARB_BUSY);
  - the index-width function idx_w(n) = clog2 with a minimum of 1;
  - the MAX_PORTS = 8 constant.
- One sub-module, l1_arb_picker: combinational. Inputs are the req vector and the start pointer; outputs are the winner index and any_req. It is used by both modes, with start fixed at 0 for fixed priority.

## Test plan
- Single port: s_req[1]=1 with addr 0x1000, we=0, m_ready after 3 wait cycles, m_rdata=0xDEADBEEF.
  - Required: m_req in cycle 1, m_addr=0x1000, s_ready[1] pulses once, s_rdata=0xDEADBEEF.
- Fixed priority, NUM_PORTS=4, requests on ports 1 and 3 held:
  - Required grant order: 1, 1, 1…, and port 3 waits until port 1 drops its request.
- Round robin (L1_ARB_RR_EN), NUM_PORTS=4, all four ports requesting continuously:
  - Required grant_idx sequence: 0,1,2,3,0, with wrap-around from 3 to 0.
- Write pass-through: port 0 with we=1, wdata=0xA5A5A5A5, be=4'b0011.
  - Required: m_we=1, m_wdata=0xA5A5A5A5, m_be=4'b0011 for the whole BUSY interval.
- Reset mid-BUSY (grant_idx=2, m_ready withheld):
  - Required: after the rst edge, m_req=0, grant_valid=0, no s_ready; the next grant goes to port 0 under priority.
- Spurious m_ready in IDLE with no requests:
  - Required: s_ready stays 0 and the state remains IDLE.
